// File: rtl/apb_mem_responder.sv
// Memory-side responder for one APB slave's Memory_Bus link.
// Byte-wide storage; each accepted read/write completes after LATENCY wait
// cycles with a one-cycle ready pulse (err alongside for out-of-range).
module apb_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       wren,
  input  logic       rden,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        op_wr_q, op_wr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        do_access;
  logic        in_range;
  logic [AW-1:0] idx;

  logic [7:0] mem [DEPTH];

  assign in_range = ({24'd0, addr_q} < DEPTH);
  assign idx      = addr_q[AW-1:0];

  // Next-state, request latching and completion/err pulse generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_wr_d   = op_wr_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce && wren && rden) begin
          err_d = 1'b1;
        end else if (ce && (wren ^ rden)) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_wr_d = wren;
          cnt_d   = 4'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!ce) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access = 1'b1;
          ready_d   = 1'b1;
          err_d     = !in_range;
          state_d   = DONE;
          if (!op_wr_q) rdata_d = in_range ? mem[idx] : '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage write; never cleared, suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (!reset && do_access && op_wr_q && in_range) mem[idx] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
